bus_datapath_gen2: RTL and testbench
====================================

// Module: bus_datapath_gen2
// PURPOSE
//  Parametrised single-bus CPU datapath: NUM_REGS x DATA_W GPRs, PC/IR/HI/LO/Y/Z/MAR/MDR, in/out ports, ALU.
//  Adds iterative signed MUL/DIV with busy/done, a req/ack memory-read handshake into MDR, and a priority bus encoder.
//  Sits between the control unit (drives the one-hot strobes below) and the memory subsystem.
// PARAMETERS
//  DATA_W    32  datapath width (>=8)
//  NUM_REGS  16  GPR count (power of 2, 2..32)
//  IMM_W     19  width of IR immediate field IR[IMM_W-1:0], sign-extended onto the bus as C
// PORTS
//  clk          in   1           rising-edge clock
//  clr          in   1           asynchronous active-low reset
//  reg_in       in   NUM_REGS    one-hot GPR write strobes (load from bus)
//  reg_out      in   NUM_REGS    GPR bus-drive requests
//  ld_pc/ld_ir/ld_hi/ld_lo/ld_y/ld_mar/ld_out  in 1 each  load named register from bus
//  ld_z         in   1           latch ALU result (starts MUL/DIV when op is MUL/DIV)
//  drv_pc/drv_hi/drv_lo/drv_zhi/drv_zlo/drv_mdr/drv_inport/drv_c  in 1 each  bus-drive requests
//  mdr_ld_bus   in   1           MDR <= bus
//  mem_rd       in   1           pulse: start memory read at MAR into MDR
//  alu_op       in   4           dp_pkg::alu_op_t
//  mem_req      out  1           read request to memory
//  mem_addr     out  DATA_W      = MAR
//  mem_ack      in   1           memory data valid
//  mem_rdata    in   DATA_W      read data
//  in_port      in   DATA_W      external input port
//  out_port     out  DATA_W      output port register
//  busy         out  1           MUL/DIV or memory read in progress
//  done         out  1           one-cycle pulse when MUL/DIV or memory read completes
//  div0         out  1           sticky, set by DIV with zero divisor; cleared by next DIV start
//  bus_mon      out  DATA_W      current bus value (debug)
// BEHAVIOUR
//  - Reset (clr=0, async): every register, out_port, mem_req, busy, done, div0 = 0; FSM -> IDLE.
//  - Bus: combinational priority select, lowest index wins: R0..R(N-1), HI, LO, ZHI, ZLO, PC, MDR, INPORT, C.
//    No requester -> bus = 0. All loads take effect on the clk edge with bus value of that cycle.
//  - Single-cycle ALU ops (ADD SUB AND OR SHR SHRA SHL ROR ROL NEG NOT INC): A=Y, B=bus; ld_z -> Z_LO=result,
//    Z_HI=0. Shift/rotate count = B[$clog2(DATA_W)-1:0]; arithmetic wraps modulo 2^DATA_W.
//  - MUL/DIV: ld_z with op MUL/DIV latches Y, bus; FSM IDLE->CALC; busy=1 for exactly DATA_W cycles, then
//    Z written and done=1 next cycle (FSM->IDLE). Signed two's complement, magnitudes iterated, sign fixed at end.
//    MUL: Z = 2*DATA_W-bit product. DIV: Z_LO=quotient, Z_HI=remainder (sign of dividend), trunc toward zero.
//    DIV by 0: Z_LO=all-ones, Z_HI=dividend, div0=1, same latency. ld_z while busy is ignored.
//  - Memory: mem_rd in IDLE -> MEMRD, mem_req=1 held with mem_addr=MAR until mem_ack; on ack edge MDR<=mem_rdata,
//    mem_req=0, done=1, ->IDLE. mem_ack same cycle as request accepted (1-cycle min). mem_rd while busy ignored.
//  - mdr_ld_bus and mem_ack same cycle: memory data wins. ld_mar during MEMRD: MAR updates, mem_addr held.
//  - Reset mid-operation: partial MUL/DIV discarded, mem_req drops immediately, Z/MDR keep reset value 0.
// CONFIGURATION
//  DP_BUS_CHECK_EN defined: output bus_err (1) added; sticky, set when >1 drive request in one cycle,
//    cleared only by reset. Undefined: port absent, multi-drive silently resolved by priority.
// STRUCTURE
//  dp_pkg: alu_op_t enum, bus source index constants, FSM state enum (IDLE, CALC, MEMRD).
//  Sub-module dp_bus_encoder: request vector -> source index + valid (and multi-drive flag).
//  MUL/DIV iterator and FSM inline in bus_datapath_gen2.
// TESTING
//  1. R3=5 via inport, drv R3 ld_y, R4=7 on bus, op ADD ld_z, drv_zlo ld R5 -> R5=12.
//  2. Y=-6, bus=7, MUL -> busy 32 cycles, done pulse, Z_HI=0xFFFFFFFF, Z_LO=0xFFFFFFD6.
//  3. Y=-17, bus=5, DIV -> Z_LO=-3, Z_HI=-2; then bus=0 DIV -> Z_LO=all-ones, Z_HI=Y, div0=1.
//  4. MAR=0x40, mem_rd, mem_ack after 3 cycles with 0xDEADBEEF -> mem_req 3 cycles, MDR=0xDEADBEEF, done.
//  5. drv R1 and drv_pc same cycle (R1=9) -> bus=9; with DP_BUS_CHECK_EN bus_err=1 and stays 1.
//  6. clr low mid-DIV and mid-MEMRD -> busy, mem_req, Z, MDR all 0 asynchronously; next op runs normally.

Source files
------------

// File: rtl/bus_datapath_gen2_pkg.sv
// Shared types for the bus_datapath_gen2 slice.
//   alu_op_t   : ALU / MUL / DIV operation select driven by the control unit
//   SRC_*      : bus source offsets placed after the NUM_REGS GPR requesters
//   dp_state_t : sequencing FSM states
package bus_datapath_gen2_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_INC  = 4'd11,
    OP_MUL  = 4'd12,
    OP_DIV  = 4'd13
  } alu_op_t;

  // Bus source index = NUM_REGS + SRC_*; GPRs occupy 0..NUM_REGS-1.
  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int SRC_C      = 7;
  localparam int N_SPECIAL  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_MEMRD = 2'd2
  } dp_state_t;

  function automatic logic is_muldiv(alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/bus_datapath_gen2_if.sv
// Memory read handshake between the datapath (master) and memory (slave).
//   mem_req   : read request, held until mem_ack
//   mem_addr  : read address
//   mem_ack   : read data valid
//   mem_rdata : read data
interface bus_datapath_gen2_if #(parameter int DATA_W = 32);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/bus_datapath_gen2_bus_encoder.sv
// Priority encoder for the shared bus: lowest requesting index wins.
//   req   : one bit per bus source
//   sel   : index of the winning source (0 when none)
//   valid : at least one request
//   multi : more than one request this cycle
module bus_datapath_gen2_bus_encoder #(
  parameter int N  = 24,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [SW-1:0] sel,
  output logic          valid,
  output logic          multi
);

  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) sel = SW'(i);
    end
  end

  assign valid = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_datapath_gen2.sv
// Single-bus CPU datapath: GPRs, PC/IR/HI/LO/Y/Z/MAR/MDR, in/out ports, ALU,
// iterative signed MUL/DIV and a req/ack memory read into MDR.
//   clk, clr            : clock, async active-low reset
//   reg_in / reg_out    : GPR load strobes / bus-drive requests
//   ld_* / drv_*        : named register loads / bus-drive requests
//   mdr_ld_bus, mem_rd  : MDR <= bus, start memory read at MAR
//   alu_op              : operation for ld_z
//   mem                 : memory handshake (master side)
//   in_port / out_port  : external ports
//   busy, done, div0    : sequencer status
//   bus_mon             : current bus value
// Build option DP_BUS_CHECK_EN adds bus_err (sticky multi-drive flag).
//
// state    | meaning
// ST_IDLE  | ready; accepts ld_z MUL/DIV and mem_rd
// ST_CALC  | MUL/DIV iterating, one bit per cycle for DATA_W cycles
// ST_MEMRD | mem_req held until mem_ack
module bus_datapath_gen2
  import bus_datapath_gen2_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 19
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic [NUM_REGS-1:0] reg_out,
  input  logic                ld_pc, ld_ir, ld_hi, ld_lo, ld_y, ld_mar, ld_out, ld_z,
  input  logic                drv_pc, drv_hi, drv_lo, drv_zhi, drv_zlo, drv_mdr, drv_inport, drv_c,
  input  logic                mdr_ld_bus,
  input  logic                mem_rd,
  input  alu_op_t             alu_op,
  bus_datapath_gen2_if.master mem,
  input  logic [DATA_W-1:0]   in_port,
  output logic [DATA_W-1:0]   out_port,
  output logic                busy,
  output logic                done,
  output logic                div0,
  output logic [DATA_W-1:0]   bus_mon
`ifdef DP_BUS_CHECK_EN
  , output logic              bus_err
`endif
);

  localparam int RW   = $clog2(NUM_REGS);
  localparam int SW   = $clog2(DATA_W);
  localparam int NSRC = NUM_REGS + N_SPECIAL;
  localparam int SELW = $clog2(NSRC);

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] pc, hi, lo, y, mar, mdr, z_hi, z_lo, bus, c_val, alu_res;
  logic [IMM_W-1:0]  ir_imm;
  logic [SELW-1:0]   src_sel;
  logic              src_valid, src_multi;

  // ---------------- bus ----------------
  bus_datapath_gen2_bus_encoder #(.N(NSRC), .SW(SELW)) u_enc (
    .req   ({drv_c, drv_inport, drv_mdr, drv_pc, drv_zlo, drv_zhi, drv_lo, drv_hi, reg_out}),
    .sel   (src_sel),
    .valid (src_valid),
    .multi (src_multi)
  );

  logic signed [IMM_W-1:0] imm_s;
  assign imm_s = ir_imm;
  assign c_val = DATA_W'(imm_s);

  always_comb begin
    bus = '0;
    if (src_valid) begin
      if (int'(src_sel) < NUM_REGS) begin
        bus = gpr[src_sel[RW-1:0]];
      end else begin
        case (int'(src_sel) - NUM_REGS)
          SRC_HI:     bus = hi;
          SRC_LO:     bus = lo;
          SRC_ZHI:    bus = z_hi;
          SRC_ZLO:    bus = z_lo;
          SRC_PC:     bus = pc;
          SRC_MDR:    bus = mdr;
          SRC_INPORT: bus = in_port;
          SRC_C:      bus = c_val;
          default:    bus = '0;
        endcase
      end
    end
  end
  assign bus_mon = bus;

`ifdef DP_BUS_CHECK_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)           bus_err <= 1'b0;
    else if (src_multi) bus_err <= 1'b1;
  end
`else
  logic unused_multi;
  assign unused_multi = src_multi;
`endif

  // ---------------- single-cycle ALU: A=Y, B=bus ----------------
  logic [SW-1:0]       sh;
  logic [2*DATA_W-1:0] rot_r, rot_l;
  assign sh    = bus[SW-1:0];
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = y + bus;
      OP_SUB:  alu_res = y - bus;
      OP_AND:  alu_res = y & bus;
      OP_OR:   alu_res = y | bus;
      OP_SHR:  alu_res = y >> sh;
      OP_SHRA: alu_res = $signed(y) >>> sh;
      OP_SHL:  alu_res = y << sh;
      OP_ROR:  alu_res = rot_r[DATA_W-1:0];
      OP_ROL:  alu_res = rot_l[2*DATA_W-1:DATA_W];
      OP_NEG:  alu_res = -y;
      OP_NOT:  alu_res = ~y;
      OP_INC:  alu_res = y + 1'b1;
      default: alu_res = '0;
    endcase
  end

  // ---------------- plain registers ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      pc <= '0; ir_imm <= '0; hi <= '0; lo <= '0; y <= '0; mar <= '0; out_port <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (reg_in[i]) gpr[i] <= bus;
      if (ld_pc)  pc       <= bus;
      if (ld_ir)  ir_imm   <= bus[IMM_W-1:0];
      if (ld_hi)  hi       <= bus;
      if (ld_lo)  lo       <= bus;
      if (ld_y)   y        <= bus;
      if (ld_mar) mar      <= bus;
      if (ld_out) out_port <= bus;
    end
  end

  // ---------------- MUL/DIV iterator ----------------
  // p holds {partial product} for MUL, {remainder, quotient} for DIV; opd is
  // the multiplicand / divisor magnitude.
  dp_state_t           state;
  logic [2*DATA_W-1:0] p, p_next, p_mul_next, p_div_next;
  logic [DATA_W-1:0]   opd, a_mag, b_mag, q_mag, r_mag, addr_q;
  logic [DATA_W:0]     mul_sum, div_rsh, div_diff;
  logic [SW-1:0]       cnt;
  logic                is_div, neg_lo, neg_r, dz, mem_req_q;

  assign a_mag = y[DATA_W-1]   ? -y   : y;
  assign b_mag = bus[DATA_W-1] ? -bus : bus;

  assign mul_sum    = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, opd} : '0);
  assign p_mul_next = {mul_sum, p[DATA_W-1:1]};

  // With a zero divisor every step "subtracts" nothing, so the quotient fills
  // with ones and the remainder ends as |dividend|, which sign-fixes back to
  // the dividend itself.
  assign div_rsh    = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
  assign div_diff   = div_rsh - {1'b0, opd};
  assign p_div_next = (dz || !div_diff[DATA_W])
                    ? {div_diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1}
                    : {div_rsh[DATA_W-1:0],  p[DATA_W-2:0], 1'b0};
  assign p_next     = is_div ? p_div_next : p_mul_next;
  assign q_mag      = p_next[DATA_W-1:0];
  assign r_mag      = p_next[2*DATA_W-1:DATA_W];

  assign mem.mem_req  = mem_req_q;
  // Address is frozen for the whole read even if MAR is reloaded meanwhile.
  assign mem.mem_addr = mem_req_q ? addr_q : mar;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE; busy <= 1'b0; done <= 1'b0; div0 <= 1'b0; mem_req_q <= 1'b0;
      addr_q <= '0; p <= '0; opd <= '0; cnt <= '0;
      is_div <= 1'b0; neg_lo <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
      z_hi <= '0; z_lo <= '0; mdr <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_MEMRD && mem.mem_ack) mdr <= mem.mem_rdata;
      else if (mdr_ld_bus)                  mdr <= bus;

      case (state)
        ST_IDLE: begin
          if (ld_z && is_muldiv(alu_op)) begin
            state  <= ST_CALC;
            busy   <= 1'b1;
            cnt    <= SW'(DATA_W - 1);
            neg_lo <= y[DATA_W-1] ^ bus[DATA_W-1];
            neg_r  <= y[DATA_W-1];
            if (alu_op == OP_DIV) begin
              is_div <= 1'b1;
              p      <= {{DATA_W{1'b0}}, a_mag};
              opd    <= b_mag;
              dz     <= (bus == '0);
              div0   <= 1'b0;
            end else begin
              is_div <= 1'b0;
              p      <= {{DATA_W{1'b0}}, b_mag};
              opd    <= a_mag;
              dz     <= 1'b0;
            end
          end else begin
            if (ld_z) begin
              z_lo <= alu_res;
              z_hi <= '0;
            end
            if (mem_rd) begin
              state     <= ST_MEMRD;
              busy      <= 1'b1;
              mem_req_q <= 1'b1;
              addr_q    <= mar;
            end
          end
        end
        ST_CALC: begin
          p   <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div) begin
              z_lo <= (neg_lo && !dz) ? -q_mag : q_mag;
              z_hi <= neg_r ? -r_mag : r_mag;
              div0 <= dz;
            end else begin
              {z_hi, z_lo} <= neg_lo ? -p_next : p_next;
            end
          end
        end
        ST_MEMRD: begin
          if (mem.mem_ack) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_datapath_gen2.sv
// Self-checking bench for bus_datapath_gen2 with a behavioural reference model.
module tb_bus_datapath_gen2;
  import bus_datapath_gen2_pkg::*;

  localparam int W  = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [NR-1:0] reg_in, reg_out;
  logic ld_pc, ld_ir, ld_hi, ld_lo, ld_y, ld_mar, ld_out, ld_z;
  logic drv_pc, drv_hi, drv_lo, drv_zhi, drv_zlo, drv_mdr, drv_inport, drv_c;
  logic mdr_ld_bus, mem_rd;
  alu_op_t alu_op;
  logic [W-1:0] in_port, out_port, bus_mon;
  logic busy, done, div0;
`ifdef DP_BUS_CHECK_EN
  logic bus_err;
`endif

  bus_datapath_gen2_if #(.DATA_W(W)) mem_if ();

  bus_datapath_gen2 #(.DATA_W(W), .NUM_REGS(NR), .IMM_W(19)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
    .ld_pc(ld_pc), .ld_ir(ld_ir), .ld_hi(ld_hi), .ld_lo(ld_lo), .ld_y(ld_y),
    .ld_mar(ld_mar), .ld_out(ld_out), .ld_z(ld_z),
    .drv_pc(drv_pc), .drv_hi(drv_hi), .drv_lo(drv_lo), .drv_zhi(drv_zhi),
    .drv_zlo(drv_zlo), .drv_mdr(drv_mdr), .drv_inport(drv_inport), .drv_c(drv_c),
    .mdr_ld_bus(mdr_ld_bus), .mem_rd(mem_rd), .alu_op(alu_op), .mem(mem_if.master),
    .in_port(in_port), .out_port(out_port), .busy(busy), .done(done), .div0(div0),
    .bus_mon(bus_mon)
`ifdef DP_BUS_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    reg_in = '0; reg_out = '0;
    ld_pc = 0; ld_ir = 0; ld_hi = 0; ld_lo = 0; ld_y = 0; ld_mar = 0; ld_out = 0; ld_z = 0;
    drv_pc = 0; drv_hi = 0; drv_lo = 0; drv_zhi = 0; drv_zlo = 0; drv_mdr = 0;
    drv_inport = 0; drv_c = 0; mdr_ld_bus = 0; mem_rd = 0; alu_op = OP_ADD;
  endtask

  task automatic put_reg(int r, logic [W-1:0] v);
    in_port = v; drv_inport = 1; reg_in[r] = 1'b1; cyc(); idle_ctl();
  endtask

  task automatic load_y(logic [W-1:0] v);
    in_port = v; drv_inport = 1; ld_y = 1; cyc(); idle_ctl();
  endtask

  task automatic load_mar(logic [W-1:0] v);
    in_port = v; drv_inport = 1; ld_mar = 1; cyc(); idle_ctl();
  endtask

  task automatic read_z(output logic [W-1:0] zlo, output logic [W-1:0] zhi);
    drv_zlo = 1; #1 zlo = bus_mon; drv_zlo = 0;
    drv_zhi = 1; #1 zhi = bus_mon; drv_zhi = 0;
  endtask

  task automatic run_md(alu_op_t op, logic [W-1:0] a, logic [W-1:0] b,
                        output int nbusy, output logic saw_done, output logic done_after,
                        output logic [W-1:0] zlo, output logic [W-1:0] zhi);
    load_y(a);
    in_port = b; drv_inport = 1; alu_op = op; ld_z = 1; cyc(); idle_ctl();
    nbusy = 0;
    while (busy && nbusy < 200) begin nbusy++; cyc(); end
    saw_done = done;
    cyc();
    done_after = done;
    read_z(zlo, zhi);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(alu_op_t op, logic [W-1:0] a, logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    n = int'(b[4:0]);
    r = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SHR:  return a >> n;
      OP_SHRA: return $signed(a) >>> n;
      OP_SHL:  return a << n;
      OP_ROR:  begin repeat (n) r = {r[0], r[W-1:1]}; return r; end
      OP_ROL:  begin repeat (n) r = {r[W-2:0], r[W-1]}; return r; end
      OP_NEG:  return 0 - a;
      OP_NOT:  return ~a;
      OP_INC:  return a + 1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [2*W-1:0] ref_md(alu_op_t op, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MUL) begin
      res = sa * sb;
    end else if (sb == 0) begin
      res = {a, {W{1'b1}}};
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[W-1:0], q[W-1:0]};
    end
    return res;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got %b want 0", div0); end
    n_tests++; if (mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_if.mem_req); end
    n_tests++; if (out_port !== '0) begin n_fail++; $display("FAIL reset_out_port got %h want 0", out_port); end
    n_tests++; if (bus_mon !== '0) begin n_fail++; $display("FAIL reset_bus_idle got %h want 0", bus_mon); end
    drv_pc = 1; #1;
    n_tests++; if (bus_mon !== '0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus_mon); end
    idle_ctl(); #1;
`ifdef DP_BUS_CHECK_EN
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
`endif
  endtask

  task automatic test_add_path();
    put_reg(3, 32'd5);
    reg_out[3] = 1; ld_y = 1; cyc(); idle_ctl();
    in_port = 32'd7; drv_inport = 1; alu_op = OP_ADD; ld_z = 1; cyc(); idle_ctl();
    drv_zlo = 1; reg_in[5] = 1; cyc(); idle_ctl();
    reg_out[5] = 1; ld_out = 1; #1;
    n_tests++; if (bus_mon !== 32'd12) begin n_fail++; $display("FAIL add_r5 got %0d want 12", bus_mon); end
    cyc(); idle_ctl();
    n_tests++; if (out_port !== 32'd12) begin n_fail++; $display("FAIL add_out_port got %0d want 12", out_port); end
    drv_zhi = 1; #1;
    n_tests++; if (bus_mon !== '0) begin n_fail++; $display("FAIL add_zhi got %h want 0", bus_mon); end
    idle_ctl();
  endtask

  task automatic test_alu_random();
    logic [W-1:0] a, b, zlo, zhi, exp;
    alu_op_t op;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = alu_op_t'(4'($urandom_range(0, 11)));
      exp = ref_alu(op, a, b);
      load_y(a);
      in_port = b; drv_inport = 1; alu_op = op; ld_z = 1; cyc(); idle_ctl();
      read_z(zlo, zhi);
      n_tests++;
      if (zlo !== exp) begin n_fail++; $display("FAIL alu_%s a=%h b=%h got %h want %h", op.name(), a, b, zlo, exp); end
      n_tests++;
      if (zhi !== '0) begin n_fail++; $display("FAIL alu_zhi_%s got %h want 0", op.name(), zhi); end
    end
  endtask

  task automatic test_imm();
    logic [W-1:0] v, exp;
    logic [18:0] imm;
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 32'h0004_0005 : $urandom;
      imm = v[18:0];
      exp = {{(W-19){imm[18]}}, imm};
      in_port = v; drv_inport = 1; ld_ir = 1; cyc(); idle_ctl();
      drv_c = 1; #1;
      n_tests++;
      if (bus_mon !== exp) begin n_fail++; $display("FAIL imm_c ir=%h got %h want %h", v, bus_mon, exp); end
      idle_ctl();
    end
  endtask

  task automatic check_md(alu_op_t op, logic [W-1:0] a, logic [W-1:0] b);
    int nbusy;
    logic saw_done, done_after;
    logic [W-1:0] zlo, zhi;
    logic [2*W-1:0] exp;
    exp = ref_md(op, a, b);
    run_md(op, a, b, nbusy, saw_done, done_after, zlo, zhi);
    n_tests++; if (nbusy != W) begin n_fail++; $display("FAIL md_busy_cycles %s got %0d want %0d", op.name(), nbusy, W); end
    n_tests++; if (saw_done !== 1'b1 || done_after !== 1'b0) begin
      n_fail++; $display("FAIL md_done_pulse %s got %b%b want 10", op.name(), saw_done, done_after); end
    n_tests++; if ({zhi, zlo} !== exp) begin
      n_fail++; $display("FAIL md_result %s a=%h b=%h got %h want %h", op.name(), a, b, {zhi, zlo}, exp); end
    if (op == OP_DIV) begin
      n_tests++; if (div0 !== (b == '0)) begin n_fail++; $display("FAIL md_div0 b=%h got %b want %b", b, div0, (b == '0)); end
    end
  endtask

  task automatic test_muldiv();
    logic [W-1:0] a, b;
    check_md(OP_MUL, -32'sd6, 32'd7);
    check_md(OP_DIV, -32'sd17, 32'd5);
    check_md(OP_DIV, -32'sd17, 32'd0);
    check_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_md(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      check_md((i % 2 == 0) ? OP_MUL : OP_DIV, a, b);
    end
  endtask

  task automatic test_mem();
    logic [W-1:0] addr, data;
    int lat, nreq;
    logic addr_ok, conflict;
    for (int t = 0; t < 6; t++) begin
      addr     = (t == 0) ? 32'h40 : $urandom;
      data     = (t == 0) ? 32'hDEAD_BEEF : $urandom;
      lat      = (t == 0) ? 3 : $urandom_range(1, 4);
      conflict = (t >= 3);
      load_mar(addr);
      mem_rd = 1; cyc(); idle_ctl();
      nreq = 0; addr_ok = 1;
      for (int k = 0; k < lat; k++) begin
        if (mem_if.mem_req === 1'b1) nreq++;
        if (mem_if.mem_addr !== addr) addr_ok = 0;
        if (k == 0 && lat > 1) begin in_port = ~addr; drv_inport = 1; ld_mar = 1; end
        if (k == lat - 1) begin
          mem_if.mem_ack = 1; mem_if.mem_rdata = data;
          if (conflict) begin in_port = ~data; drv_inport = 1; mdr_ld_bus = 1; end
        end
        cyc(); idle_ctl();
        mem_if.mem_ack = 0;
      end
      n_tests++; if (nreq != lat) begin n_fail++; $display("FAIL mem_req_cycles got %0d want %0d", nreq, lat); end
      n_tests++; if (!addr_ok) begin n_fail++; $display("FAIL mem_addr_hold got changed want %h", addr); end
      n_tests++; if (done !== 1'b1 || mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mem_complete done/req/busy got %b%b%b want 100", done, mem_if.mem_req, busy); end
      drv_mdr = 1; #1;
      n_tests++; if (bus_mon !== data) begin n_fail++; $display("FAIL mem_mdr got %h want %h", bus_mon, data); end
      idle_ctl();
    end
  endtask

  task automatic test_bus_priority();
    logic [W-1:0] rv [NR];
    logic [W-1:0] pcv, hiv, exp;
    logic [NR-1:0] mask;
    logic dp, dh, di;
    for (int r = 0; r < NR; r++) begin rv[r] = $urandom; put_reg(r, rv[r]); end
    rv[1] = 32'd9; put_reg(1, 32'd9);
    pcv = $urandom; in_port = pcv; drv_inport = 1; ld_pc = 1; cyc(); idle_ctl();
    hiv = $urandom; in_port = hiv; drv_inport = 1; ld_hi = 1; cyc(); idle_ctl();
`ifdef DP_BUS_CHECK_EN
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err_early got %b want 0", bus_err); end
`endif
    reg_out[1] = 1; drv_pc = 1; #1;
    n_tests++; if (bus_mon !== 32'd9) begin n_fail++; $display("FAIL prio_r1_pc got %h want 9", bus_mon); end
    cyc(); idle_ctl();
`ifdef DP_BUS_CHECK_EN
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL bus_err_set got %b want 1", bus_err); end
`endif
    for (int i = 0; i < 20; i++) begin
      mask = NR'($urandom & $urandom & $urandom);
      dp = 1'($urandom); dh = 1'($urandom); di = 1'($urandom);
      in_port = $urandom;
      exp = '0;
      if (di) exp = in_port;
      if (dp) exp = pcv;
      if (dh) exp = hiv;
      for (int r = NR - 1; r >= 0; r--) if (mask[r]) exp = rv[r];
      reg_out = mask; drv_pc = dp; drv_hi = dh; drv_inport = di; #1;
      n_tests++;
      if (bus_mon !== exp) begin n_fail++; $display("FAIL prio_rand mask=%h pc=%b hi=%b in=%b got %h want %h", mask, dp, dh, di, bus_mon, exp); end
      cyc(); idle_ctl();
    end
`ifdef DP_BUS_CHECK_EN
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL bus_err_sticky got %b want 1", bus_err); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] zlo, zhi;
    load_y(-32'sd17);
    in_port = 32'd5; drv_inport = 1; alu_op = OP_DIV; ld_z = 1; cyc(); idle_ctl();
    repeat (10) cyc();
    #2 clr = 0; #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_div_busy got %b want 0", busy); end
    read_z(zlo, zhi);
    n_tests++; if ({zhi, zlo} !== '0) begin n_fail++; $display("FAIL rst_div_z got %h want 0", {zhi, zlo}); end
    #3 clr = 1; cyc();
    load_mar(32'h123);
    mem_rd = 1; cyc(); idle_ctl();
    n_tests++; if (mem_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mem_req_pre got %b want 1", mem_if.mem_req); end
    #2 clr = 0; #1;
    n_tests++; if (mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem_req got %b busy %b want 0 0", mem_if.mem_req, busy); end
    drv_mdr = 1; #1;
    n_tests++; if (bus_mon !== '0) begin n_fail++; $display("FAIL rst_mdr got %h want 0", bus_mon); end
    idle_ctl();
    #3 clr = 1; cyc();
    check_md(OP_MUL, $urandom, $urandom);
    load_mar(32'h80);
    mem_rd = 1; cyc(); idle_ctl();
    mem_if.mem_ack = 1; mem_if.mem_rdata = 32'hCAFE_F00D; cyc(); mem_if.mem_ack = 0;
    n_tests++; if (done !== 1'b1 || mem_if.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_mem done/req got %b%b want 10", done, mem_if.mem_req); end
    drv_mdr = 1; #1;
    n_tests++; if (bus_mon !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL post_rst_mdr got %h want cafef00d", bus_mon); end
    idle_ctl();
  endtask

  initial begin
    idle_ctl();
    in_port = '0;
    mem_if.mem_ack = 0;
    mem_if.mem_rdata = '0;
    #12;
    test_reset();
    #3 clr = 1;
    cyc();
    test_add_path();
    test_alu_random();
    test_imm();
    test_muldiv();
    test_mem();
    test_bus_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
